systolic_pe_mac: RTL and testbench
==================================

// Module: systolic_pe_mac
// PURPOSE
//  Parametrised systolic-array processing element for the matrix multiplier.
//  Accepts one row/column operand pair per handshake and multiplies it on an
//  iterative shift-add multiplier (signed or unsigned). Adds the product into
//  a wide accumulator with optional saturation and a sticky overflow flag.
//  Forwards operands to the east/south neighbours and emits the dot product
//  when the last term is accumulated.
// PARAMETERS
//  DATA_W  16            operand width in bits (>=2)
//  ACC_W   2*DATA_W+8    accumulator/result width (>=2*DATA_W)
//  SIGNED  1             1: two's-complement operands/accumulator; 0: unsigned
//  SAT     0             1: clamp accumulator on overflow; 0: wrap modulo 2^ACC_W
// PORTS
//  clk           in   1        clock, all state updates on rising edge
//  rst           in   1        synchronous, active-high reset
//  in_valid      in   1        operand pair valid
//  in_ready      out  1        PE idle, can accept operands
//  row_in        in   DATA_W   row (A) operand
//  col_in        in   DATA_W   column (B) operand
//  acc_clr       in   1        sampled on accept: start a new dot product (acc := 0)
//  last          in   1        sampled on accept: final term of the dot product
//  row_out       out  DATA_W   forwarded row operand (east)
//  col_out       out  DATA_W   forwarded column operand (south)
//  fwd_valid     out  1        1-cycle pulse: row_out/col_out updated
//  result        out  ACC_W    completed dot product
//  result_valid  out  1        1-cycle pulse: result updated
//  overflow      out  1        sticky: accumulator overflowed in the current dot product
// BEHAVIOUR
//  Reset: state=IDLE, acc=0, row_out=col_out=0, result=0, fwd_valid=0,
//   result_valid=0, overflow=0, in_ready=0 while rst is high and 1 after.
//  in_ready = (state==IDLE) && !rst. Accept = in_valid && in_ready.
//  FSM: IDLE -accept-> MUL -(DATA_W steps)-> ACC -> IDLE (unconditional).
//  Accept edge T: latch operands, acc_clr and last. If acc_clr: acc:=0, overflow:=0.
//  MUL at edges T+1..T+DATA_W: one multiplier bit per edge, LSB first.
//   With SIGNED=1, multiply magnitudes and negate the 2*DATA_W product if the
//   operand signs differ. (-2^(DATA_W-1))^2 must be exact.
//  ACC at edge T+DATA_W+1:
//   acc += product, sign-extended (SIGNED) or zero-extended to ACC_W.
//   row_out/col_out := latched operands; fwd_valid=1 for this cycle only.
//   If last: result := new acc value, result_valid=1 for this cycle only.
//   Accumulator is retained after last. It is cleared only by acc_clr on a
//   later accept.
//  Throughput: one pair per DATA_W+2 cycles. in_ready is high in the cycle
//   after ACC, and a back-to-back accept is permitted in that cycle.
//  Overflow:
//   Detection is signed overflow of the ACC_W add (SIGNED=1) or carry-out (SIGNED=0).
//   On overflow, overflow:=1. With SAT=1, acc clamps to max/min (signed) or
//   all-ones (unsigned). With SAT=0, acc wraps.
//   result reflects the clamped or wrapped value.
//  in_valid while busy: ignored, with no side effects. Operands must be held
//   only until accept.
//  acc_clr and last together: single-term dot product, result = product.
//  rst mid-MUL/ACC: operation aborted. No fwd_valid or result_valid pulse;
//   all outputs return to reset values on that edge.
// TESTING
//  DATA_W=8,SIGNED=0: accept (3,5,clr,last) -> fwd_valid at T+9, result=15 with
//   result_valid same cycle, row_out=3, col_out=5.
//  SIGNED=1: (-128,-128,clr,last) -> result=16384. (-7,6,clr,last) -> result=-42.
//  4-term dot (1,2),(3,4),(5,6),(7,8), clr on first, last on fourth -> result=100,
//   exactly one result_valid pulse, four fwd_valid pulses, in_ready low 9 of every 10 cycles.
//  ACC_W=16,SIGNED=1,SAT=1: repeated 127*127 terms -> acc clamps at 32767,
//   overflow=1 sticky; next clr accept clears overflow. Same with SAT=0 -> wraps.
//  Assert rst at T+4 mid-MUL -> no pulses, outputs at reset values, in_ready=1
//   the cycle after rst drops. in_valid held during busy -> no extra accept.

Source files
------------

// File: rtl/systolic_pe_mac.sv
// systolic_pe_mac
//   Processing element for a systolic matrix multiplier. Each accepted
//   row/column operand pair is multiplied on a bit-serial shift-add
//   multiplier (one multiplier bit per clock, LSB first). The product is then
//   added into a wide accumulator. The operands are forwarded east/south, and
//   the dot product is emitted when the term flagged "last" is accumulated.
//
// Parameters
//   DATA_W  operand width (>=2)
//   ACC_W   accumulator / result width (>=2*DATA_W)
//   SIGNED  1: two's-complement operands and accumulator, 0: unsigned
//   SAT     1: clamp the accumulator on overflow, 0: wrap modulo 2^ACC_W
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   in_valid/in_ready   operand handshake; in_ready is high only when idle
//   row_in, col_in      A (row) and B (column) operands
//   acc_clr, last       sampled on accept: start a new sum / final term
//   row_out, col_out    forwarded operands, updated with a fwd_valid pulse
//   result              completed dot product, updated with a result_valid pulse
//   overflow            sticky overflow of the current dot product
module systolic_pe_mac #(
  parameter int DATA_W = 16,
  parameter int ACC_W  = 2*DATA_W+8,
  parameter bit SIGNED = 1'b1,
  parameter bit SAT    = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] row_in,
  input  logic [DATA_W-1:0] col_in,
  input  logic              acc_clr,
  input  logic              last,
  output logic [DATA_W-1:0] row_out,
  output logic [DATA_W-1:0] col_out,
  output logic              fwd_valid,
  output logic [ACC_W-1:0]  result,
  output logic              result_valid,
  output logic              overflow
);

  localparam int PROD_W = 2*DATA_W;
  localparam int CNT_W  = $clog2(DATA_W);

  typedef enum logic [1:0] {IDLE, MUL, ACC} state_t;

  state_t              state_reg;
  logic [CNT_W-1:0]    cnt_reg;
  logic [DATA_W-1:0]   row_reg;
  logic [DATA_W-1:0]   col_reg;
  logic                last_reg;
  logic                neg_reg;
  logic [PROD_W-1:0]   mcand_reg;
  logic [DATA_W-1:0]   mplier_reg;
  logic [PROD_W-1:0]   prod_reg;
  logic [ACC_W-1:0]    acc_reg;

  logic                accept;
  logic                row_neg;
  logic                col_neg;
  logic [DATA_W-1:0]   row_mag;
  logic [DATA_W-1:0]   col_mag;
  logic [PROD_W-1:0]   mul_next;
  logic [PROD_W-1:0]   prod_fix;
  logic [ACC_W-1:0]    prod_ext;
  logic [ACC_W:0]      sum_full;
  logic [ACC_W-1:0]    sum;
  logic [ACC_W-1:0]    clamp;
  logic                add_ovf;
  logic [ACC_W-1:0]    acc_next;

  assign in_ready = (state_reg == IDLE) && !rst;
  assign accept   = in_valid && in_ready;

  // Operands are multiplied as magnitudes. An unsigned DATA_W-bit magnitude
  // holds 2^(DATA_W-1), so the most-negative operand squares exactly.
  always_comb begin
    row_neg = SIGNED && row_in[DATA_W-1];
    col_neg = SIGNED && col_in[DATA_W-1];
    row_mag = row_neg ? (~row_in + 1'b1) : row_in;
    col_mag = col_neg ? (~col_in + 1'b1) : col_in;
  end

  // One shift-add step: add the shifted multiplicand when the current
  // multiplier LSB is set.
  assign mul_next = prod_reg + (mplier_reg[0] ? mcand_reg : '0);

  // Accumulate stage: restore the product sign, extend it to ACC_W, then add
  // it with overflow detection and optional clamping.
  always_comb begin
    prod_fix = neg_reg ? (~prod_reg + 1'b1) : prod_reg;
    if (SIGNED) begin
      prod_ext = ACC_W'($signed(prod_fix));
    end else begin
      prod_ext = ACC_W'(prod_fix);
    end
    sum_full = {1'b0, acc_reg} + {1'b0, prod_ext};
    sum      = sum_full[ACC_W-1:0];
    if (SIGNED) begin
      // Overflow occurs only when both addends share a sign that the sum lacks.
      add_ovf = (acc_reg[ACC_W-1] == prod_ext[ACC_W-1]) &&
                (sum[ACC_W-1] != acc_reg[ACC_W-1]);
      clamp   = prod_ext[ACC_W-1] ? {1'b1, {(ACC_W-1){1'b0}}}
                                  : {1'b0, {(ACC_W-1){1'b1}}};
    end else begin
      add_ovf = sum_full[ACC_W];
      clamp   = '1;
    end
    acc_next = (SAT && add_ovf) ? clamp : sum;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= IDLE;
      cnt_reg      <= '0;
      row_reg      <= '0;
      col_reg      <= '0;
      last_reg     <= 1'b0;
      neg_reg      <= 1'b0;
      mcand_reg    <= '0;
      mplier_reg   <= '0;
      prod_reg     <= '0;
      acc_reg      <= '0;
      row_out      <= '0;
      col_out      <= '0;
      fwd_valid    <= 1'b0;
      result       <= '0;
      result_valid <= 1'b0;
      overflow     <= 1'b0;
    end else begin
      fwd_valid    <= 1'b0;
      result_valid <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (accept) begin
            row_reg    <= row_in;
            col_reg    <= col_in;
            last_reg   <= last;
            neg_reg    <= row_neg ^ col_neg;
            mcand_reg  <= PROD_W'(row_mag);
            mplier_reg <= col_mag;
            prod_reg   <= '0;
            cnt_reg    <= '0;
            if (acc_clr) begin
              acc_reg  <= '0;
              overflow <= 1'b0;
            end
            state_reg  <= MUL;
          end
        end
        MUL: begin
          prod_reg   <= mul_next;
          mcand_reg  <= mcand_reg << 1;
          mplier_reg <= mplier_reg >> 1;
          cnt_reg    <= cnt_reg + CNT_W'(1);
          if (cnt_reg == CNT_W'(DATA_W-1)) begin
            state_reg <= ACC;
          end
        end
        ACC: begin
          acc_reg   <= acc_next;
          overflow  <= overflow | add_ovf;
          row_out   <= row_reg;
          col_out   <= col_reg;
          fwd_valid <= 1'b1;
          if (last_reg) begin
            result       <= acc_next;
            result_valid <= 1'b1;
          end
          state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_systolic_pe_mac.sv
// Bench for systolic_pe_mac: five PE configurations share one operand stream.
// Each is compared against an integer-arithmetic model of dot-product
// accumulation with wrap or clamp.
module tb_systolic_pe_mac;

  localparam int W = 8;
  localparam int N = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic         in_valid = 1'b0;
  logic         acc_clr  = 1'b0;
  logic         last     = 1'b0;
  logic [W-1:0] row_in   = '0;
  logic [W-1:0] col_in   = '0;

  logic         rdy [N];
  logic [W-1:0] ro  [N];
  logic [W-1:0] co  [N];
  logic         fv  [N];
  logic         rv  [N];
  logic         ov  [N];
  logic [63:0]  res [N];

  logic [23:0] res0, res1;
  logic [15:0] res2, res3, res4;
  assign res[0] = 64'(res0);
  assign res[1] = 64'(res1);
  assign res[2] = 64'(res2);
  assign res[3] = 64'(res3);
  assign res[4] = 64'(res4);

  // Configuration table for the model: accumulator width, signedness, saturation.
  int accw [N] = '{24, 24, 16, 16, 16};
  bit sg   [N] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
  bit st   [N] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

  systolic_pe_mac #(.DATA_W(W), .ACC_W(24), .SIGNED(1'b0), .SAT(1'b0)) u0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy[0]),
    .row_in(row_in), .col_in(col_in), .acc_clr(acc_clr), .last(last),
    .row_out(ro[0]), .col_out(co[0]), .fwd_valid(fv[0]), .result(res0),
    .result_valid(rv[0]), .overflow(ov[0]));
  systolic_pe_mac #(.DATA_W(W), .ACC_W(24), .SIGNED(1'b1), .SAT(1'b0)) u1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy[1]),
    .row_in(row_in), .col_in(col_in), .acc_clr(acc_clr), .last(last),
    .row_out(ro[1]), .col_out(co[1]), .fwd_valid(fv[1]), .result(res1),
    .result_valid(rv[1]), .overflow(ov[1]));
  systolic_pe_mac #(.DATA_W(W), .ACC_W(16), .SIGNED(1'b1), .SAT(1'b1)) u2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy[2]),
    .row_in(row_in), .col_in(col_in), .acc_clr(acc_clr), .last(last),
    .row_out(ro[2]), .col_out(co[2]), .fwd_valid(fv[2]), .result(res2),
    .result_valid(rv[2]), .overflow(ov[2]));
  systolic_pe_mac #(.DATA_W(W), .ACC_W(16), .SIGNED(1'b1), .SAT(1'b0)) u3 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy[3]),
    .row_in(row_in), .col_in(col_in), .acc_clr(acc_clr), .last(last),
    .row_out(ro[3]), .col_out(co[3]), .fwd_valid(fv[3]), .result(res3),
    .result_valid(rv[3]), .overflow(ov[3]));
  systolic_pe_mac #(.DATA_W(W), .ACC_W(16), .SIGNED(1'b0), .SAT(1'b1)) u4 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy[4]),
    .row_in(row_in), .col_in(col_in), .acc_clr(acc_clr), .last(last),
    .row_out(ro[4]), .col_out(co[4]), .fwd_valid(fv[4]), .result(res4),
    .result_valid(rv[4]), .overflow(ov[4]));

  int vectors     = 0;
  int miscompares = 0;

  // Reference state per configuration: the accumulator as a mathematical
  // integer (kept in range), the sticky overflow, and the last reported result.
  longint macc [N];
  bit     movf [N];
  longint mres [N];

  function automatic longint mask(int w);
    return (longint'(1) << w) - 1;
  endfunction

  task automatic chk(input string tag, input int i, input logic [63:0] obs,
                     input logic [63:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s[u%0d] observed=%0h expected=%0h", tag, i, obs, expv);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      macc[i] = 0;
      movf[i] = 1'b0;
      mres[i] = 0;
    end
  endtask

  task automatic model_term(input int i, input logic [W-1:0] a,
                            input logic [W-1:0] b, input bit clr, input bit lst);
    longint p, s, mx, mn, t;
    if (sg[i]) p = longint'($signed(a)) * longint'($signed(b));
    else       p = longint'(a) * longint'(b);
    if (clr) begin
      macc[i] = 0;
      movf[i] = 1'b0;
    end
    s = macc[i] + p;
    if (sg[i]) begin
      mx = (longint'(1) << (accw[i] - 1)) - 1;
      mn = -(longint'(1) << (accw[i] - 1));
    end else begin
      mx = mask(accw[i]);
      mn = 0;
    end
    if (s > mx || s < mn) begin
      movf[i] = 1'b1;
      if (st[i]) begin
        macc[i] = (s > mx) ? mx : mn;
      end else begin
        t = s & mask(accw[i]);
        if (sg[i] && t > mx) t = t - (longint'(1) << accw[i]);
        macc[i] = t;
      end
    end else begin
      macc[i] = s;
    end
    if (lst) mres[i] = macc[i];
  endtask

  // Called just after a falling edge. Offers one pair, then follows the
  // operation for DATA_W+2 cycles and finishes at the falling edge of the
  // cycle in which the PE is idle again, so calls can run back to back.
  task automatic txn(input logic [W-1:0] a, input logic [W-1:0] b,
                     input bit clr, input bit lst, input bit hold);
    row_in = a; col_in = b; acc_clr = clr; last = lst; in_valid = 1'b1;
    for (int i = 0; i < N; i++) chk("ready_before", i, 64'(rdy[i]), 64'd1);
    @(posedge clk);
    for (int i = 0; i < N; i++) model_term(i, a, b, clr, lst);
    for (int k = 1; k <= W + 2; k++) begin
      @(negedge clk);
      if (k == 1) begin
        // Scramble the inputs: the PE must work from its latched copies.
        row_in  = W'($urandom);
        col_in  = W'($urandom);
        acc_clr = 1'($urandom);
        last    = 1'($urandom);
        in_valid = hold;
      end
      if (k < W + 2) begin
        for (int i = 0; i < N; i++) begin
          chk("busy_ready", i, 64'(rdy[i]), 64'd0);
          chk("busy_fwd", i, 64'(fv[i]), 64'd0);
          chk("busy_rv", i, 64'(rv[i]), 64'd0);
        end
      end else begin
        for (int i = 0; i < N; i++) begin
          chk("fwd_valid", i, 64'(fv[i]), 64'd1);
          chk("row_out", i, 64'(ro[i]), 64'(a));
          chk("col_out", i, 64'(co[i]), 64'(b));
          chk("result_valid", i, 64'(rv[i]), 64'(lst));
          chk("result", i, res[i], 64'(mres[i] & mask(accw[i])));
          chk("overflow", i, 64'(ov[i]), 64'(movf[i]));
          chk("ready_after", i, 64'(rdy[i]), 64'd1);
        end
      end
    end
    in_valid = 1'b0;
    $display("txn a=%02h b=%02h clr=%0d last=%0d hold=%0d res=%0h/%0h/%0h/%0h/%0h ovf=%0d%0d%0d%0d%0d",
             a, b, clr, lst, hold, res[0], res[1], res[2], res[3], res[4],
             ov[0], ov[1], ov[2], ov[3], ov[4]);
  endtask

  task automatic check_reset_outputs(input string tag);
    for (int i = 0; i < N; i++) begin
      chk({tag, "_ready"}, i, 64'(rdy[i]), 64'd0);
      chk({tag, "_fwd"}, i, 64'(fv[i]), 64'd0);
      chk({tag, "_rv"}, i, 64'(rv[i]), 64'd0);
      chk({tag, "_result"}, i, res[i], 64'd0);
      chk({tag, "_ovf"}, i, 64'(ov[i]), 64'd0);
      chk({tag, "_row_out"}, i, 64'(ro[i]), 64'd0);
      chk({tag, "_col_out"}, i, 64'(co[i]), 64'd0);
    end
  endtask

  // Reset asserted so that the edge at T+4 (mid-multiply) samples it.
  task automatic abort_txn(input logic [W-1:0] a, input logic [W-1:0] b);
    row_in = a; col_in = b; acc_clr = 1'b1; last = 1'b1; in_valid = 1'b1;
    @(posedge clk);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      if (k == 1) in_valid = 1'b0;
      if (k == 4) rst = 1'b1;
    end
    @(negedge clk);
    model_reset();
    check_reset_outputs("abort");
    rst = 1'b0;
    @(negedge clk);
    for (int i = 0; i < N; i++) begin
      chk("abort_ready_after", i, 64'(rdy[i]), 64'd1);
      chk("abort_fwd_after", i, 64'(fv[i]), 64'd0);
      chk("abort_rv_after", i, 64'(rv[i]), 64'd0);
    end
    $display("txn a=%02h b=%02h aborted by reset", a, b);
  endtask

  initial begin
    model_reset();
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;
    @(negedge clk);
    for (int i = 0; i < N; i++) chk("ready_out_of_reset", i, 64'(rdy[i]), 64'd1);

    // Single-term products, including the most-negative square.
    txn(8'd3, 8'd5, 1'b1, 1'b1, 1'b0);
    txn(8'h80, 8'h80, 1'b1, 1'b1, 1'b0);
    txn(8'hF9, 8'd6, 1'b1, 1'b1, 1'b0);

    // Four-term dot product; in_valid held high through one busy period.
    txn(8'd1, 8'd2, 1'b1, 1'b0, 1'b0);
    txn(8'd3, 8'd4, 1'b0, 1'b0, 1'b1);
    txn(8'd5, 8'd6, 1'b0, 1'b0, 1'b0);
    txn(8'd7, 8'd8, 1'b0, 1'b1, 1'b0);

    // Repeated 127*127 terms: the 16-bit accumulators clamp or wrap.
    txn(8'd127, 8'd127, 1'b1, 1'b0, 1'b0);
    for (int j = 0; j < 3; j++) txn(8'd127, 8'd127, 1'b0, 1'b0, 1'b0);
    txn(8'd127, 8'd127, 1'b0, 1'b1, 1'b0);
    // A clearing accept drops the sticky overflow.
    txn(8'd2, 8'd3, 1'b1, 1'b1, 1'b0);

    // Build up overflow again, then abort mid-multiply with reset.
    txn(8'd127, 8'd127, 1'b1, 1'b0, 1'b0);
    txn(8'd127, 8'd127, 1'b0, 1'b0, 1'b0);
    txn(8'd127, 8'd127, 1'b0, 1'b0, 1'b0);
    abort_txn(8'd9, 8'd9);

    // Randomised sequence.
    for (int j = 0; j < 40; j++) begin
      txn(W'($urandom), W'($urandom), ($urandom_range(0, 3) == 0),
          ($urandom_range(0, 2) == 0), 1'($urandom));
    end

    // After the last operation the pulses must have dropped.
    @(negedge clk);
    for (int i = 0; i < N; i++) begin
      chk("idle_fwd", i, 64'(fv[i]), 64'd0);
      chk("idle_rv", i, 64'(rv[i]), 64'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
